// File: rtl/counter_sequencer_if.sv
// Control and status bundle between the board wrapper and the counter sequencer.
// The wrapper side (buttons, switches, LEDs) uses the master modport; the
// sequencer uses the slave modport.
interface counter_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             up_down;
    logic             auto_reload;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] q;
    logic             tick;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, stop, pause, up_down, auto_reload, load_val, terminal,
        input  q, tick, busy, done, state
    );

    modport slave (
        input  start, stop, pause, up_down, auto_reload, load_val, terminal,
        output q, tick, busy, done, state
    );
endinterface

// File: rtl/counter_sequencer.sv
// Run-control sequencer for the clock-divided counter datapath. An embedded
// prescaler turns clock_in into a step tick; the FSM starts, pauses, stops and
// reloads the count and either halts or auto-reloads at a programmable terminal.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | stopped; q holds its last value, waiting for start
// RUN   | prescaler running; q steps up/down on every prescaler wrap
// PAUSE | prescaler and q frozen; busy stays high
// DONE  | terminal reached with auto_reload=0; done held high
//
// Input priority each cycle is stop > start > pause. Holding start high in RUN
// restarts every cycle, so the count never advances; button edge detection is
// the wrapper's job.
module counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 25000000,
    parameter int DIV_W = 25
) (
    input  logic               clock_in,
    input  logic               reset,
    counter_sequencer_if.slave cs
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(DIV - 1);

    state_t           state_r, state_nx;
    logic [WIDTH-1:0] q_r, q_nx;
    logic [DIV_W-1:0] presc_r, presc_nx;
    logic             tick_r, tick_nx;
    logic             done_r, done_nx;
    logic             busy_r, busy_nx;
    logic             presc_last;

    assign presc_last = (presc_r == PRESC_MAX);

    // State, count, prescaler and registered status outputs.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            q_r     <= '0;
            presc_r <= '0;
            tick_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            q_r     <= q_nx;
            presc_r <= presc_nx;
            tick_r  <= tick_nx;
            done_r  <= done_nx;
            busy_r  <= busy_nx;
        end
    end

    // Next-state, count step and prescaler update; a tick is only taken in RUN
    // when no stop, start or pause claims the cycle, so those discard it.
    always_comb begin
        state_nx = state_r;
        q_nx     = q_r;
        presc_nx = presc_r;
        tick_nx  = 1'b0;
        done_nx  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!cs.stop && cs.start) begin
                    state_nx = ST_RUN;
                    q_nx     = cs.load_val;
                    presc_nx = '0;
                end
            end

            ST_RUN: begin
                if (cs.stop) begin
                    state_nx = ST_IDLE;
                end else if (cs.start) begin
                    q_nx     = cs.load_val;
                    presc_nx = '0;
                end else if (cs.pause) begin
                    state_nx = ST_PAUSE;
                end else if (presc_last) begin
                    presc_nx = '0;
                    tick_nx  = 1'b1;
                    if (q_r == cs.terminal) begin
                        done_nx = 1'b1;
                        if (cs.auto_reload) begin
                            q_nx = cs.load_val;
                        end else begin
                            state_nx = ST_DONE;
                        end
                    end else if (cs.up_down) begin
                        q_nx = q_r + 1'b1;
                    end else begin
                        q_nx = q_r - 1'b1;
                    end
                end else begin
                    presc_nx = presc_r + 1'b1;
                end
            end

            ST_PAUSE: begin
                if (cs.stop) begin
                    state_nx = ST_IDLE;
                end else if (cs.start) begin
                    state_nx = ST_RUN;
                    q_nx     = cs.load_val;
                    presc_nx = '0;
                end else if (!cs.pause) begin
                    state_nx = ST_RUN;
                end
            end

            ST_DONE: begin
                if (cs.stop) begin
                    state_nx = ST_IDLE;
                end else if (cs.start) begin
                    state_nx = ST_RUN;
                    q_nx     = cs.load_val;
                    presc_nx = '0;
                end else begin
                    done_nx = 1'b1;
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx == ST_RUN) || (state_nx == ST_PAUSE);
    end

    // Status outputs come straight from registers so they change with the state.
    always_comb begin
        cs.q     = q_r;
        cs.tick  = tick_r;
        cs.done  = done_r;
        cs.busy  = busy_r;
        cs.state = state_r;
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: two instances (DIV=4 and DIV=1) share the same
// stimulus. A reference model pushes the expected outputs of each instance to a
// queue every cycle; the queues are popped and compared after the clock edge.
// Directed checks against hand-derived constants cover the key scenarios.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       up_down = 1'b1;
    logic       auto_reload = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] terminal = 4'd0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    counter_sequencer_if #(.WIDTH(4)) if_a ();
    counter_sequencer_if #(.WIDTH(4)) if_b ();

    assign if_a.start       = start;
    assign if_a.stop        = stop;
    assign if_a.pause       = pause;
    assign if_a.up_down     = up_down;
    assign if_a.auto_reload = auto_reload;
    assign if_a.load_val    = load_val;
    assign if_a.terminal    = terminal;
    assign if_b.start       = start;
    assign if_b.stop        = stop;
    assign if_b.pause       = pause;
    assign if_b.up_down     = up_down;
    assign if_b.auto_reload = auto_reload;
    assign if_b.load_val    = load_val;
    assign if_b.terminal    = terminal;

    counter_sequencer #(.WIDTH(4), .DIV(4), .DIV_W(3)) dut_a (
        .clock_in (clk),
        .reset    (reset),
        .cs       (if_a.slave)
    );

    counter_sequencer #(.WIDTH(4), .DIV(1), .DIV_W(1)) dut_b (
        .clock_in (clk),
        .reset    (reset),
        .cs       (if_b.slave)
    );

    // Packed observation: {state, busy, done, tick, q}
    logic [8:0] obs_a, obs_b;
    assign obs_a = {if_a.state, if_a.busy, if_a.done, if_a.tick, if_a.q};
    assign obs_b = {if_b.state, if_b.busy, if_b.done, if_b.tick, if_b.q};

    typedef struct {
        logic [1:0] state;
        logic [3:0] q;
        int         presc;
        logic       tick;
        logic       done;
    } mdl_t;

    localparam mdl_t MDL_RST = '{state: 2'd0, q: 4'd0, presc: 0, tick: 1'b0, done: 1'b0};

    mdl_t ma = MDL_RST;
    mdl_t mb = MDL_RST;
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] mdl_pack(input mdl_t m);
        logic busy;
        busy = (m.state == 2'd1) || (m.state == 2'd2);
        return {m.state, busy, m.done, m.tick, m.q};
    endfunction

    // Behavioural reference: one clock of the sequencer from the current inputs.
    function automatic mdl_t mdl_next(input mdl_t m, input int div);
        mdl_t n;
        n = m;
        n.tick = 1'b0;
        n.done = 1'b0;
        case (m.state)
            2'd0: if (!stop && start) begin
                n.state = 2'd1; n.q = load_val; n.presc = 0;
            end
            2'd1: begin
                if (stop) n.state = 2'd0;
                else if (start) begin n.q = load_val; n.presc = 0; end
                else if (pause) n.state = 2'd2;
                else if (m.presc == div - 1) begin
                    n.presc = 0;
                    n.tick = 1'b1;
                    if (m.q == terminal) begin
                        n.done = 1'b1;
                        if (auto_reload) n.q = load_val;
                        else n.state = 2'd3;
                    end else if (up_down) n.q = m.q + 4'd1;
                    else n.q = m.q - 4'd1;
                end else n.presc = m.presc + 1;
            end
            2'd2: begin
                if (stop) n.state = 2'd0;
                else if (start) begin n.state = 2'd1; n.q = load_val; n.presc = 0; end
                else if (!pause) n.state = 2'd1;
            end
            default: begin
                if (stop) n.state = 2'd0;
                else if (start) begin n.state = 2'd1; n.q = load_val; n.presc = 0; end
                else n.done = 1'b1;
            end
        endcase
        return n;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            if (reset) begin
                ma = MDL_RST;
                mb = MDL_RST;
            end else begin
                ma = mdl_next(ma, 4);
                mb = mdl_next(mb, 1);
            end
            exp_a.push_back(mdl_pack(ma));
            exp_b.push_back(mdl_pack(mb));
            @(posedge clk);
            #1;
            chk("a_out", 32'(obs_a), 32'(exp_a.pop_front()));
            chk("b_out", 32'(obs_b), 32'(exp_b.pop_front()));
        end
    endtask

    initial begin
        #1;
        chk("rst_async_a", 32'(obs_a), 32'd0);
        chk("rst_async_b", 32'(obs_b), 32'd0);
        step(2);
        reset = 1'b0;
        step(2);

        // 1: count up 3..7 then halt in DONE
        load_val = 4'd3; terminal = 4'd7; up_down = 1'b1; auto_reload = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        chk("t1_q_load", 32'(if_a.q), 32'd3);
        chk("t1_state_run", 32'(if_a.state), 32'd1);
        step(4);
        chk("t1_q4", 32'(if_a.q), 32'd4);
        chk("t1_tick", 32'(if_a.tick), 32'd1);
        step(12);
        chk("t1_q7", 32'(if_a.q), 32'd7);
        step(4);
        chk("t1_done_state", 32'(obs_a), {23'd0, 2'b11, 1'b0, 1'b1, 1'b1, 4'd7});
        step(3);
        chk("t1_done_held", 32'(if_a.done), 32'd1);

        // 2: count down 2..0 with auto-reload
        load_val = 4'd2; terminal = 4'd0; up_down = 1'b0; auto_reload = 1'b1;
        start = 1'b1; step(1); start = 1'b0;
        chk("t2_q_load", 32'(if_a.q), 32'd2);
        chk("t2_done_clr", 32'(if_a.done), 32'd0);
        step(11);
        chk("t2_q0", 32'(if_a.q), 32'd0);
        step(1);
        chk("t2_reload", 32'(obs_a), {23'd0, 2'b01, 1'b1, 1'b1, 1'b1, 4'd2});
        step(1);
        chk("t2_done_pulse_end", 32'(if_a.done), 32'd0);

        // 3: wrap upward 14,15,0,1 then downward 1,0,15,14
        stop = 1'b1; step(1); stop = 1'b0;
        chk("t3_stop_idle", 32'(if_a.state), 32'd0);
        load_val = 4'd14; terminal = 4'd1; up_down = 1'b1; auto_reload = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(8);
        chk("t3_wrap_up", 32'(if_a.q), 32'd0);
        step(8);
        chk("t3_up_done", 32'(if_a.state), 32'd3);
        chk("t3_up_q", 32'(if_a.q), 32'd1);
        load_val = 4'd1; terminal = 4'd14; up_down = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(8);
        chk("t3_wrap_dn", 32'(if_a.q), 32'd15);
        step(8);
        chk("t3_dn_done", 32'(obs_a), {23'd0, 2'b11, 1'b0, 1'b1, 1'b1, 4'd14});

        // 4: pause with prescaler at 2, resume
        load_val = 4'd0; terminal = 4'd15; up_down = 1'b1; auto_reload = 1'b1;
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        pause = 1'b1; step(10);
        chk("t4_pause", 32'(obs_a), {23'd0, 2'b10, 1'b1, 1'b0, 1'b0, 4'd0});
        pause = 1'b0; step(1);
        chk("t4_resume_state", 32'(if_a.state), 32'd1);
        step(1);
        chk("t4_no_tick_yet", 32'(if_a.q), 32'd0);
        step(1);
        chk("t4_first_tick", 32'(obs_a), {23'd0, 2'b01, 1'b1, 1'b0, 1'b1, 4'd1});

        // 5: stop and start together on a tick cycle
        step(3);
        stop = 1'b1; start = 1'b1; step(1); stop = 1'b0;
        chk("t5_stop_wins", 32'(obs_a), {23'd0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1});
        load_val = 4'd9; step(1); start = 1'b0;
        chk("t5_restart", 32'(obs_a), {23'd0, 2'b01, 1'b1, 1'b0, 1'b0, 4'd9});

        // Held start keeps restarting
        start = 1'b1; step(6); start = 1'b0;
        chk("hold_start_q", 32'(if_a.q), 32'd9);

        // 6: async reset mid-run, prescaler nonzero
        step(2);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_rst_a", 32'(obs_a), 32'd0);
        chk("t6_async_rst_b", 32'(obs_b), 32'd0);
        step(2);
        reset = 1'b0;

        // DIV=1 steps every cycle
        load_val = 4'd5; terminal = 4'd15; up_down = 1'b1; auto_reload = 1'b1;
        start = 1'b1; step(1); start = 1'b0;
        chk("t6_b_load", 32'(if_b.q), 32'd5);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("t6_b_step", 32'(if_b.q), 32'(5 + k));
        end

        // Random traffic checked by the scoreboard
        for (int r = 0; r < 400; r++) begin
            start       = ($urandom_range(0, 14) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            up_down     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) auto_reload = ~auto_reload;
            if ($urandom_range(0, 9) == 0) load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) terminal = 4'($urandom_range(0, 15));
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
